// File: rtl/imem_responder_if.sv
// Instruction-fetch bus between the fetch stage (master) and the
// instruction memory responder (slave).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. A response transfers on a rising edge where
// rsp_valid and rsp_ready are both 1. While rsp_valid is 1, rsp_instr,
// rsp_err and rsp_halt hold steady. flush is a one-cycle kill from the
// branch path. It drops any request that is outstanding and blocks
// acceptance in that cycle.
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        rsp_halt;
    logic        flush;

    modport master (
        output req_valid, req_addr, rsp_ready, flush,
        input  req_ready, rsp_valid, rsp_instr, rsp_err, rsp_halt
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush,
        output req_ready, rsp_valid, rsp_instr, rsp_err, rsp_halt
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder. It holds a byte-addressed store and
// returns little-endian 32-bit words LATENCY cycles after it accepts a
// request. The response flags misaligned and out-of-range fetches, and
// it flags HALT opcodes. A byte-wide load port writes the program.
//
// The memory powers up unknown and is written only through the load port.
module imem_responder #(
    parameter int          DEPTH_BYTES = 4096,
    parameter int          LATENCY     = 1,
    parameter logic [10:0] HALT_OPC    = 11'h7FF,
    localparam int         AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          reset,
    imem_responder_if.slave bus,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_byte,
    output logic [1:0]    dbg_state
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [63:0]   addr_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_instr_q;
    logic          rsp_err_q;
    logic          rsp_halt_q;

    logic [7:0]    mem [DEPTH_BYTES];

    // Program load: one byte per edge. Writes are ignored while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && load_en) begin
            mem[load_addr] <= load_byte;
        end
    end

    // Decode of the latched address. The range test runs on the full 64-bit
    // value, so the truncated byte indices are used only when they cannot wrap.
    logic          misaligned;
    logic          out_of_range;
    logic          fetch_err;
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic [31:0]   word;

    assign misaligned   = (addr_q[1:0] != 2'b00);
    assign out_of_range = (addr_q > 64'(DEPTH_BYTES - 4));
    assign fetch_err    = misaligned | out_of_range;
    assign idx0         = addr_q[AW-1:0];
    assign idx1         = idx0 + AW'(1);
    assign idx2         = idx0 + AW'(2);
    assign idx3         = idx0 + AW'(3);
    assign word         = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};

    // Request/response FSM with registered outputs. The acceptance edge
    // enters WAIT. WAIT then lasts count+1 cycles, so rsp_valid rises
    // exactly LATENCY edges after acceptance. The memory read on the edge
    // that enters RESP sees the contents before any load on that same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            addr_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            rsp_halt_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q && !bus.flush) begin
                        addr_q      <= bus.req_addr;
                        count       <= CW'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.flush) begin
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end else if (count == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= fetch_err;
                        rsp_instr_q <= fetch_err ? 32'h0 : word;
                        rsp_halt_q  <= !fetch_err && (word[31:21] == HALT_OPC);
                        state       <= RESP;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                RESP: begin
                    // A flush and a consumed response have the same outcome.
                    if (bus.flush || bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_halt  = rsp_halt_q;
    assign dbg_state     = state;

endmodule
